// File: rtl/ps2_host_tx.sv
// ============================================================================
// Module      : ps2_host_tx
// Description : Host-to-device PS/2 transmitter. Sends one command byte to the
//               device over open-drain clock/data lines and reports ACK, NACK
//               or timeout with a one-cycle tx_done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_done,
    output logic       tx_ack,
    output logic       tx_error,
    output logic       busy
);

    localparam int c_MAXT = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int c_TW   = $clog2(c_MAXT + 1);
    localparam int c_FW   = $clog2(FILTER_LEN + 1);

    localparam logic [c_TW-1:0] c_INH_LAST = c_TW'(INHIBIT_CYCLES - 1);
    localparam logic [c_TW-1:0] c_TO_LAST  = c_TW'(TIMEOUT_CYCLES - 1);
    localparam logic [c_FW-1:0] c_FLAST    = c_FW'(FILTER_LEN - 1);
    localparam logic [3:0]      c_STOP_IDX = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5,
        ST_DONE      = 3'd6,
        ST_ABORT     = 3'd7
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [1:0]        w_pin;
    logic [1:0]        w_filt;        // [0] = clock, [1] = data
    logic              r_clk_prev;
    logic              w_fall;
    logic [7:0]        r_shreg;
    logic              r_parity;
    logic [3:0]        r_bit_idx;
    logic [c_TW-1:0]   r_timer;
    logic              r_ack;
    logic              r_ack_hold;
    logic              r_err_hold;
    logic              w_timeout;
    logic              w_bit_oe;

    assign w_pin = {ps2_data_in, ps2_clk_in};

    // Per-pin conditioning: 2-FF synchronizer followed by a run-length filter
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cond
            logic            r_s1;
            logic            r_s2;
            logic            r_f;
            logic [c_FW-1:0] r_cnt;

            // Filtered level flips only after FILTER_LEN consecutive differing samples
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s1  <= 1'b1;
                    r_s2  <= 1'b1;
                    r_f   <= 1'b1;
                    r_cnt <= '0;
                end else begin
                    r_s1 <= w_pin[gi];
                    r_s2 <= r_s1;
                    if (r_s2 == r_f) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_FLAST) begin
                        r_f   <= r_s2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_filt[gi] = r_f;
        end
    endgenerate

    // Previous filtered clock level, used to detect the device's falling edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_prev <= w_filt[0];
        end
    end

    assign w_fall    = r_clk_prev & ~w_filt[0];
    assign w_timeout = (r_timer == c_TO_LAST);

    // Pull-low enable for the bit currently presented: data bits, parity, then stop (released)
    always_comb begin
        w_bit_oe = 1'b0;
        if (r_bit_idx < 4'd8) begin
            w_bit_oe = ~r_shreg[r_bit_idx[2:0]];
        end else if (r_bit_idx == 4'd8) begin
            w_bit_oe = ~r_parity;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and line/handshake outputs
    always_comb begin
        w_state_next = r_state;
        tx_ready     = 1'b0;
        busy         = 1'b1;
        ps2_clk_oe   = 1'b0;
        ps2_data_oe  = 1'b0;
        tx_done      = 1'b0;
        tx_ack       = r_ack_hold;
        tx_error     = r_err_hold;
        case (r_state)
            ST_IDLE: begin
                tx_ready = 1'b1;
                busy     = 1'b0;
                if (tx_valid) w_state_next = ST_INHIBIT;
            end
            ST_INHIBIT: begin
                // Device clock activity is ignored here; the host owns the bus
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = (r_timer == c_INH_LAST);
                if (r_timer == c_INH_LAST) w_state_next = ST_REQ;
            end
            ST_REQ: begin
                ps2_data_oe = 1'b1;
                if (w_fall)         w_state_next = ST_SHIFT;
                else if (w_timeout) w_state_next = ST_ABORT;
            end
            ST_SHIFT: begin
                ps2_data_oe = w_bit_oe;
                if (w_fall) begin
                    if (r_bit_idx == c_STOP_IDX) w_state_next = ST_ACK;
                end else if (w_timeout) begin
                    w_state_next = ST_ABORT;
                end
            end
            ST_ACK: begin
                if (w_fall)         w_state_next = ST_WAIT_IDLE;
                else if (w_timeout) w_state_next = ST_ABORT;
            end
            ST_WAIT_IDLE: begin
                if (w_filt == 2'b11) w_state_next = ST_DONE;
                else if (w_timeout)  w_state_next = ST_ABORT;
            end
            ST_DONE: begin
                tx_done      = 1'b1;
                tx_ack       = r_ack;
                tx_error     = 1'b0;
                w_state_next = ST_IDLE;
            end
            ST_ABORT: begin
                tx_done      = 1'b1;
                tx_ack       = 1'b0;
                tx_error     = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Datapath: byte latch, bit index, shared inhibit/timeout timer, ack capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg    <= '0;
            r_parity   <= 1'b0;
            r_bit_idx  <= '0;
            r_timer    <= '0;
            r_ack      <= 1'b0;
            r_ack_hold <= 1'b0;
            r_err_hold <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (tx_valid) begin
                        r_shreg   <= tx_data;
                        r_parity  <= ~^tx_data;
                        r_bit_idx <= '0;
                        r_timer   <= '0;
                        r_ack     <= 1'b0;
                    end
                end
                ST_INHIBIT: begin
                    r_timer <= (r_timer == c_INH_LAST) ? '0 : r_timer + 1'b1;
                end
                ST_REQ, ST_SHIFT, ST_ACK, ST_WAIT_IDLE: begin
                    r_timer <= w_fall ? '0 : r_timer + 1'b1;
                    if (r_state == ST_SHIFT && w_fall && r_bit_idx != c_STOP_IDX) begin
                        r_bit_idx <= r_bit_idx + 1'b1;
                    end
                    if (r_state == ST_ACK && w_fall) begin
                        r_ack <= ~w_filt[1];
                    end
                end
                ST_DONE: begin
                    r_ack_hold <= r_ack;
                    r_err_hold <= 1'b0;
                end
                ST_ABORT: begin
                    r_ack_hold <= 1'b0;
                    r_err_hold <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
// ============================================================================
// Module      : tb_ps2_host_tx
// Description : Self-checking bench for ps2_host_tx with a PS/2 device model
//               on wired-AND lines and a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ps2_host_tx;

    localparam int INHIBIT_CYCLES = 20;
    localparam int TIMEOUT_CYCLES = 2000;
    localparam int FILTER_LEN     = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       tx_done;
    logic       tx_ack;
    logic       tx_error;
    logic       busy;

    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;
    wire  ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
    wire  ps2_data_line = ~(ps2_data_oe | dev_data_low);

    int pass_cnt  = 0;
    int total_cnt = 0;
    int done_cnt  = 0;
    logic last_ack = 1'b0;
    logic last_err = 1'b0;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INHIBIT_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .FILTER_LEN    (FILTER_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_in (ps2_clk_line),
        .ps2_data_in(ps2_data_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .tx_done    (tx_done),
        .tx_ack     (tx_ack),
        .tx_error   (tx_error),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Record every completion pulse and its result flags
    always @(negedge clk) begin
        if (tx_done === 1'b1) begin
            done_cnt = done_cnt + 1;
            last_ack = tx_ack;
            last_err = tx_error;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1);
    end

    // Reference frame as the device should see it: start, LSB-first data, odd parity, stop
    function automatic logic [10:0] exp_frame(input logic [7:0] d);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        f[9]  = (($countones(d) % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic send_byte(input logic [7:0] d);
        @(negedge clk);
        total_cnt++;
        if (tx_ready !== 1'b1) $display("FAIL send_ready: tx_ready=%b required 1", tx_ready);
        else pass_cnt++;
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Device model: waits for the request-to-send, then clocks 12 periods of 40 cycles,
    // sampling data on rising edges; stops early (clock held low) after fall n_falls if nonzero
    task automatic dev_run(input bit ack_en, input int n_falls,
                           output logic [10:0] seen, output bit ok);
        int n;
        seen = '1;
        ok   = 1'b0;
        n    = 0;
        while (!(ps2_clk_oe === 1'b0 && ps2_data_line === 1'b0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) return;
        ok      = 1'b1;
        seen[0] = ps2_data_line;
        repeat (10) @(negedge clk);
        for (int k = 1; k <= 12; k++) begin
            dev_clk_low = 1'b1;
            if (k == n_falls) begin
                repeat (10) @(negedge clk);
                return;
            end
            repeat (20) @(negedge clk);
            dev_clk_low = 1'b0;
            if (k <= 10) seen[k] = ps2_data_line;
            if (k == 10 && ack_en) dev_data_low = 1'b1;
            repeat (20) @(negedge clk);
        end
        dev_data_low = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int bound, output bit got);
        int n;
        n = 0;
        while (done_cnt == d0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        got = (done_cnt != d0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        total_cnt += 6;
        if (tx_ready !== 1'b1)    $display("FAIL reset_ready: %b required 1", tx_ready);    else pass_cnt++;
        if (busy !== 1'b0)        $display("FAIL reset_busy: %b required 0", busy);         else pass_cnt++;
        if (ps2_clk_oe !== 1'b0)  $display("FAIL reset_clk_oe: %b required 0", ps2_clk_oe); else pass_cnt++;
        if (ps2_data_oe !== 1'b0) $display("FAIL reset_data_oe: %b required 0", ps2_data_oe); else pass_cnt++;
        if (tx_done !== 1'b0)     $display("FAIL reset_done: %b required 0", tx_done);      else pass_cnt++;
        if ({tx_ack, tx_error} !== 2'b00) $display("FAIL reset_flags: %b required 00", {tx_ack, tx_error}); else pass_cnt++;
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_frame(input logic [7:0] d, input bit ack_en);
        logic [10:0] seen;
        logic [10:0] exp;
        bit ok, got;
        int d0;
        d0  = done_cnt;
        exp = exp_frame(d);
        send_byte(d);
        dev_run(ack_en, 0, seen, ok);
        wait_done(d0, 200, got);
        repeat (5) @(negedge clk);
        total_cnt += 6;
        if (!ok)  $display("FAIL frame_start %h: no request-to-send seen, required one", d); else pass_cnt++;
        if (seen !== exp) $display("FAIL frame_bits %h: saw %b required %b", d, seen, exp); else pass_cnt++;
        if (done_cnt - d0 != 1) $display("FAIL frame_done %h: %0d pulses required 1", d, done_cnt - d0); else pass_cnt++;
        if (last_ack !== ack_en) $display("FAIL frame_ack %h: %b required %b", d, last_ack, ack_en); else pass_cnt++;
        if (last_err !== 1'b0) $display("FAIL frame_err %h: %b required 0", d, last_err); else pass_cnt++;
        if (tx_ready !== 1'b1 || ps2_clk_oe !== 1'b0) $display("FAIL frame_idle %h: ready=%b clk_oe=%b required 1/0", d, tx_ready, ps2_clk_oe); else pass_cnt++;
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            test_frame(8'($urandom_range(255)), bit'($urandom_range(1)));
        end
    endtask

    task automatic test_timeout();
        int n_inh, n_req;
        send_byte(8'hFF);
        n_inh = 0;
        while (ps2_clk_oe === 1'b1 && n_inh < 100) begin
            n_inh++;
            @(negedge clk);
        end
        n_req = 0;
        while (ps2_data_oe === 1'b1 && ps2_clk_oe === 1'b0 && tx_done !== 1'b1 && n_req < 3000) begin
            n_req++;
            @(negedge clk);
        end
        total_cnt += 5;
        if (n_inh != INHIBIT_CYCLES) $display("FAIL timeout_inhibit: %0d cycles required %0d", n_inh, INHIBIT_CYCLES); else pass_cnt++;
        if (n_req != TIMEOUT_CYCLES) $display("FAIL timeout_req: %0d cycles required %0d", n_req, TIMEOUT_CYCLES); else pass_cnt++;
        if (tx_done !== 1'b1) $display("FAIL timeout_done: %b required 1", tx_done); else pass_cnt++;
        if ({tx_ack, tx_error} !== 2'b01) $display("FAIL timeout_flags: ack/err=%b required 01", {tx_ack, tx_error}); else pass_cnt++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) $display("FAIL timeout_lines: %b required 00", {ps2_clk_oe, ps2_data_oe}); else pass_cnt++;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (tx_error !== 1'b1) $display("FAIL timeout_hold: tx_error=%b required 1", tx_error); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [10:0] seen;
        bit ok, got;
        int d0;
        logic busy_seen;
        d0 = done_cnt;
        send_byte(8'h3C);
        fork
            dev_run(1'b1, 0, seen, ok);
            begin
                repeat (150) @(negedge clk);
                busy_seen = busy;
                tx_data   = 8'hAA;
                tx_valid  = 1'b1;
                repeat (3) @(negedge clk);
                tx_valid  = 1'b0;
            end
        join
        wait_done(d0, 200, got);
        repeat (100) @(negedge clk);
        total_cnt += 5;
        if (busy_seen !== 1'b1) $display("FAIL b2b_busy: %b required 1", busy_seen); else pass_cnt++;
        if (seen !== exp_frame(8'h3C)) $display("FAIL b2b_bits: saw %b required %b", seen, exp_frame(8'h3C)); else pass_cnt++;
        if (done_cnt - d0 != 1) $display("FAIL b2b_done: %0d pulses required 1", done_cnt - d0); else pass_cnt++;
        if (last_ack !== 1'b1) $display("FAIL b2b_ack: %b required 1", last_ack); else pass_cnt++;
        if (ps2_clk_oe !== 1'b0 || tx_ready !== 1'b1) $display("FAIL b2b_idle: clk_oe=%b ready=%b required 0/1", ps2_clk_oe, tx_ready); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [10:0] seen;
        bit ok;
        int d0;
        d0 = done_cnt;
        send_byte(8'hED);
        dev_run(1'b1, 5, seen, ok);
        rst = 1'b1;
        @(negedge clk);
        total_cnt += 4;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) $display("FAIL rstmid_lines: %b required 00", {ps2_clk_oe, ps2_data_oe}); else pass_cnt++;
        if (tx_ready !== 1'b1) $display("FAIL rstmid_ready: %b required 1", tx_ready); else pass_cnt++;
        if (busy !== 1'b0) $display("FAIL rstmid_busy: %b required 0", busy); else pass_cnt++;
        if (tx_done !== 1'b0) $display("FAIL rstmid_done: %b required 0", tx_done); else pass_cnt++;
        @(negedge clk);
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        rst = 1'b0;
        repeat (30) @(negedge clk);
        total_cnt++;
        if (done_cnt != d0) $display("FAIL rstmid_nodone: %0d pulses required 0", done_cnt - d0); else pass_cnt++;
        test_frame(8'hED, 1'b1);
    endtask

    initial begin
        test_reset();
        test_frame(8'hED, 1'b1);
        test_frame(8'h01, 1'b1);
        test_frame(8'h00, 1'b1);
        test_frame(8'hFF, 1'b1);
        test_frame(8'hF4, 1'b0);
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random(6);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
